// File: rtl/sprite_line_eval_pkg.sv
// Shared sprite constants and the 32-bit OAM/view entry layout.
// Used by the line evaluator and the tile renderers.
package sprite_line_eval_pkg;

    localparam int SPR_OAM_DEPTH = 64;
    localparam int SPRITE_NUM_MAX = 8;
    localparam int SPR_TILE_H = 8;
    localparam logic [31:0] SPR_EMPTY_ENTRY = 32'hFFFF_0000;

    localparam int POSX_HI = 31;
    localparam int POSX_LO = 24;
    localparam int POSY_HI = 23;
    localparam int POSY_LO = 16;
    localparam int TILE_HI = 15;
    localparam int TILE_LO = 8;
    localparam int ATTR_HI = 7;
    localparam int ATTR_LO = 0;

    typedef struct packed {
        logic [7:0] posX;
        logic [7:0] posY;
        logic [7:0] tileIndex;
        logic       hFlip;
        logic       vFlip;
        logic [1:0] paletteChoice;
        logic [3:0] reserved;
    } spriteEntry_t;

    function automatic logic [7:0] entryPosY(input logic [31:0] e);
        return e[POSY_HI:POSY_LO];
    endfunction

endpackage

// File: rtl/sprite_y_hit.sv
// Vertical sprite/line intersection test in 9-bit space.
// Sprites near the bottom never wrap back to line 0.
module sprite_y_hit
    import sprite_line_eval_pkg::*;
#(
    parameter int TILE_H = SPR_TILE_H
) (
    input  logic [7:0] posY,
    input  logic [7:0] line,
    output logic       hit
);

    logic [8:0] yTop;
    logic [8:0] yEnd;
    logic [8:0] lineExt;

    assign yTop    = {1'b0, posY};
    assign yEnd    = yTop + 9'(TILE_H);
    assign lineExt = {1'b0, line};
    assign hit     = (yTop <= lineExt) && (lineExt < yEnd);

endmodule

// File: rtl/sprite_line_eval.sv
// Per-line OAM scan that copies visible sprites into the view RAM bank
// the renderer will read on the following line.
module sprite_line_eval
    import sprite_line_eval_pkg::*;
#(
    parameter int          OAM_DEPTH   = SPR_OAM_DEPTH,
    parameter int          VIEW_DEPTH  = SPRITE_NUM_MAX,
    parameter int          TILE_H      = SPR_TILE_H,
    parameter logic [31:0] EMPTY_ENTRY = SPR_EMPTY_ENTRY,
    localparam int AW = $clog2(OAM_DEPTH),
    localparam int VW = $clog2(VIEW_DEPTH),
    localparam int CW = VW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          lineStart,
    input  logic [7:0]    targetLine,
    output logic [AW-1:0] oamAddr,
    input  logic [31:0]   oamData,
    output logic          viewWe,
    output logic [VW-1:0] viewAddr,
    output logic [31:0]   viewData,
    output logic          viewBank,
    output logic [CW-1:0] viewCount,
    output logic          overflow,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] FILL = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state;
    logic [7:0]    line;
    logic          rdValid;
    logic          issueDone;
    logic [CW-1:0] fillPtr;
    logic          yHit;
    logic          hit;
    logic          full;
    logic [CW-1:0] countNext;

    sprite_y_hit #(.TILE_H(TILE_H)) uYHit (
        .posY (entryPosY(oamData)),
        .line (line),
        .hit  (yHit)
    );

    assign hit       = (state == SCAN) && rdValid && yHit;
    assign full      = (viewCount == CW'(VIEW_DEPTH));
    assign countNext = (hit && !full) ? viewCount + CW'(1) : viewCount;
    assign done      = (state == DONE);

    always_comb begin
        viewWe   = 1'b0;
        viewAddr = '0;
        viewData = '0;
        if (hit && !full) begin
            viewWe   = 1'b1;
            viewAddr = viewCount[VW-1:0];
            viewData = oamData;
        end else if (state == FILL) begin
            viewWe   = 1'b1;
            viewAddr = fillPtr[VW-1:0];
            viewData = EMPTY_ENTRY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            line      <= '0;
            rdValid   <= 1'b0;
            issueDone <= 1'b0;
            fillPtr   <= '0;
            oamAddr   <= '0;
            viewBank  <= 1'b0;
            viewCount <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (lineStart) begin
                        line      <= targetLine;
                        viewBank  <= ~viewBank;
                        viewCount <= '0;
                        overflow  <= 1'b0;
                        oamAddr   <= '0;
                        rdValid   <= 1'b0;
                        issueDone <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    // issue runs one address ahead of the check
                    rdValid <= !issueDone;
                    if (!issueDone) begin
                        if (oamAddr == AW'(OAM_DEPTH - 1))
                            issueDone <= 1'b1;
                        else
                            oamAddr <= oamAddr + AW'(1);
                    end
                    viewCount <= countNext;
                    if (hit && full) begin
                        overflow <= 1'b1;
                        state    <= DONE;
                    end else if (issueDone) begin
                        fillPtr <= countNext;
                        state   <= (countNext == CW'(VIEW_DEPTH)) ? DONE : FILL;
                    end
                end
                FILL: begin
                    fillPtr <= fillPtr + CW'(1);
                    if (fillPtr == CW'(VIEW_DEPTH - 1))
                        state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_line_eval.sv
// Randomized bench for sprite_line_eval against a list-based model
// of which sprites land on a line and what the view RAM receives.
module tb_sprite_line_eval;

    localparam logic [31:0] EMPTY = 32'hFFFF_0000;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        lineStart;
    logic [7:0]  targetLine;
    logic [5:0]  oamAddr;
    logic [31:0] oamData;
    logic        viewWe;
    logic [2:0]  viewAddr;
    logic [31:0] viewData;
    logic        viewBank;
    logic [3:0]  viewCount;
    logic        overflow;
    logic        busy;
    logic        done;

    logic [31:0] oam [64];
    wr_t         expW[$];
    wr_t         monE;
    int          expCnt;
    bit          expOvf;
    int          expLat;
    bit          expBank;
    int          wrSeen;
    int          checks = 0;
    int          errors = 0;

    sprite_line_eval dut (
        .clk        (clk),
        .rstn       (rstn),
        .lineStart  (lineStart),
        .targetLine (targetLine),
        .oamAddr    (oamAddr),
        .oamData    (oamData),
        .viewWe     (viewWe),
        .viewAddr   (viewAddr),
        .viewData   (viewData),
        .viewBank   (viewBank),
        .viewCount  (viewCount),
        .overflow   (overflow),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) oamData <= oam[oamAddr];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit modelHit(input int py, input int ln);
        return (py <= ln) && (ln < py + 8);
    endfunction

    task automatic buildExp(input int L);
        int n;
        n = 0;
        expW.delete();
        for (int i = 0; i < 64; i++) begin
            int py;
            py = int'(oam[i][23:16]);
            if (modelHit(py, L)) begin
                if (n < 8) expW.push_back('{n, oam[i]});
                n++;
            end
        end
        expOvf = (n > 8);
        expCnt = expOvf ? 8 : n;
        if (!expOvf)
            for (int s = expCnt; s < 8; s++) expW.push_back('{s, EMPTY});
        expLat = 65 + (8 - expCnt) + 1;
    endtask

    always @(negedge clk) begin
        if (rstn && viewWe) begin
            wrSeen++;
            if (expW.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %h, none expected",
                         viewAddr, viewData);
            end else begin
                monE = expW.pop_front();
                chk("write_addr", 32'(viewAddr), monE.addr);
                chk("write_data", viewData, monE.data);
            end
        end
    end

    task automatic checkResetOuts(input string tag);
        chk({tag, "_oamAddr"}, 32'(oamAddr), 0);
        chk({tag, "_viewWe"}, 32'(viewWe), 0);
        chk({tag, "_viewAddr"}, 32'(viewAddr), 0);
        chk({tag, "_viewData"}, viewData, 0);
        chk({tag, "_viewBank"}, 32'(viewBank), 0);
        chk({tag, "_viewCount"}, 32'(viewCount), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    task automatic runLine(input int L, input int pulse2, input int L2);
        int cyc;
        buildExp(L);
        targetLine = 8'(L);
        lineStart = 1'b1;
        expBank = ~expBank;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            lineStart = (pulse2 != 0) && (cyc == pulse2);
            if (lineStart) targetLine = 8'(L2);
            @(negedge clk);
        end while (!done && cyc < 300);
        lineStart = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles, line %0d", cyc, L);
        end else begin
            if (!expOvf) chk("done_latency", cyc, expLat);
            chk("viewCount", 32'(viewCount), expCnt);
            chk("overflow", 32'(overflow), 32'(expOvf));
            chk("viewBank", 32'(viewBank), 32'(expBank));
            chk("busy_at_done", 32'(busy), 1);
        end
        chk("pending_writes", expW.size(), 0);
        expW.delete();
        @(posedge clk);
        @(negedge clk);
        chk("done_pulse", 32'(done), 0);
        chk("busy_after", 32'(busy), 0);
        chk("count_hold", 32'(viewCount), expCnt);
    endtask

    task automatic clearOam();
        for (int i = 0; i < 64; i++) oam[i] = EMPTY;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        lineStart = 1'b0;
        targetLine = 8'd0;
        expBank = 1'b0;
        wrSeen = 0;
        clearOam();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOuts("reset");
        rstn = 1'b1;

        // model pins
        chk("pin_hit_4_11", 32'(modelHit(4, 11)), 1);
        chk("pin_hit_4_12", 32'(modelHit(4, 12)), 0);
        chk("pin_hit_fc_0", 32'(modelHit(8'hFC, 0)), 0);
        buildExp(10);
        chk("pin_empty_lat", expLat, 74);
        chk("pin_empty_writes", expW.size(), 8);

        runLine(10, 0, 0);

        oam[3] = 32'h200A_05C0;
        oam[9] = 32'h4005_0610;
        buildExp(12);
        chk("pin_two_a0", expW[0].data, 32'h200A_05C0);
        chk("pin_two_a1", expW[1].data, 32'h4005_0610);
        chk("pin_two_cnt", expCnt, 2);
        runLine(12, 0, 0);

        // second lineStart while busy must be ignored
        runLine(12, 5, 5);

        clearOam();
        oam[0] = 32'h1004_2200;
        runLine(11, 0, 0);
        runLine(12, 0, 0);
        oam[0] = 32'h10FC_2200;
        runLine(0, 0, 0);

        clearOam();
        for (int i = 0; i < 10; i++)
            oam[i] = {8'(i * 16), 8'h00, 8'(i), 8'h30};
        buildExp(3);
        chk("pin_ovf", 32'(expOvf), 1);
        runLine(3, 0, 0);

        clearOam();
        for (int i = 0; i < 8; i++)
            oam[i * 7] = {8'(i), 8'h00, 8'(i + 1), 8'h80};
        runLine(3, 0, 0);

        // reset in the middle of a scan
        clearOam();
        for (int i = 0; i < 6; i++)
            oam[i] = {8'(i), 8'd40, 8'(i), 8'h00};
        begin
            int cyc;
            buildExp(42);
            targetLine = 8'd42;
            lineStart = 1'b1;
            wrSeen = 0;
            cyc = 0;
            do begin
                @(posedge clk);
                #1;
                lineStart = 1'b0;
                cyc++;
                @(negedge clk);
                #1;
            end while (wrSeen < 3 && cyc < 200);
            chk("mid_reset_writes", 32'(wrSeen >= 3), 1);
            @(posedge clk);
            #1 rstn = 1'b0;
            @(posedge clk);
            @(negedge clk);
            checkResetOuts("midreset");
            expW.delete();
            expBank = 1'b0;
            rstn = 1'b1;
        end
        runLine(42, 0, 0);

        for (int r = 0; r < 25; r++) begin
            int L;
            int dens;
            L = $urandom_range(0, 239);
            dens = $urandom_range(1, 6);
            for (int i = 0; i < 64; i++) begin
                int k;
                int py;
                k = $urandom_range(0, 15);
                if (k < dens)
                    py = (L + 256 - 9 + $urandom_range(0, 17)) % 256;
                else if (k < 12)
                    py = $urandom_range(0, 255);
                else
                    py = 255;
                oam[i] = {8'($urandom), 8'(py), 16'($urandom)};
            end
            runLine(L, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
